// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] inst;
    logic            fault;
  } resp_entry_t;

  // Entry returned for any fetch that cannot be served from memory.
  function automatic resp_entry_t fault_entry(input logic [XLEN-1:0] addr);
    resp_entry_t e;
    e.addr  = addr;
    e.inst  = NOP_INST;
    e.fault = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/imem_resp_fifo.sv
// In-order response FIFO with a registered head (slot 0) and a flush that
// drops all queued entries while still honouring a same-cycle write.
module imem_resp_fifo
  import imem_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush_i,
  input  logic        wr_i,
  input  resp_entry_t wr_data_i,
  input  logic        pop_i,
  output resp_entry_t head_o,
  output logic        head_vld_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  resp_entry_t   ent_q [FIFO_DEPTH];
  resp_entry_t   ent_d [FIFO_DEPTH];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_pop;
  logic          vld_q;

  // Shift on pop so the head always sits in slot 0, then append the write.
  always_comb begin
    ent_d   = ent_q;
    cnt_pop = cnt_q;
    if (pop_i && (cnt_q != '0)) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        ent_d[i] = ent_q[i+1];
      end
      cnt_pop = cnt_q - CW'(1);
    end
    if (flush_i) begin
      cnt_pop = '0;
    end
    cnt_d = cnt_pop;
    if (wr_i && (cnt_pop < CW'(FIFO_DEPTH))) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (CW'(i) == cnt_pop) begin
          ent_d[i] = wr_data_i;
        end
      end
      cnt_d = cnt_pop + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
      vld_q <= (cnt_d != '0);
    end
  end

  assign head_o     = ent_q[0];
  assign head_vld_o = vld_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency fetch pipeline feeding an
// in-order response FIFO. Optional IMEM_MISALIGN_CHECK_EN faults misaligned PCs.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_inst,
  output logic [31:0] resp_addr,
  output logic        resp_fault,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic          rd_oor;
  logic          wr_oor;
  logic          rd_fault;
  logic          accept;
  logic          pop;
  logic [OW-1:0] out_q;
  logic [OW-1:0] out_d;
  resp_entry_t   acc_ent;
  resp_entry_t   fifo_ent;
  logic          fifo_wr;
  resp_entry_t   head;
  logic          head_vld;
  logic          unused_lo;

  assign unused_lo = ^{req_addr[1:0], wr_addr[1:0]};

  assign rd_idx = req_addr[AW+1:2];
  assign rd_oor = |req_addr[31:AW+2];
  assign wr_idx = wr_addr[AW+1:2];
  assign wr_oor = |wr_addr[31:AW+2];

`ifdef IMEM_MISALIGN_CHECK_EN
  assign rd_fault = rd_oor | (|req_addr[1:0]);
`else
  assign rd_fault = rd_oor;
`endif

  // Flush forces ready so the redirect target is always taken.
  assign pop       = head_vld && resp_ready;
  assign req_ready = (out_q < OW'(FIFO_DEPTH)) || pop || flush;
  assign accept    = req_valid && req_ready;

  // Read happens before the edge, so a same-cycle loader write is not seen.
  always_comb begin
    acc_ent = rd_fault ? fault_entry(req_addr) : '0;
    if (!rd_fault) begin
      acc_ent.addr  = req_addr;
      acc_ent.inst  = mem_q[rd_idx];
      acc_ent.fault = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !wr_oor) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  // LATENCY-1 register stages between accept and the FIFO write port.
  generate
    if (LATENCY <= 1) begin : g_nopipe
      assign fifo_ent = acc_ent;
      assign fifo_wr  = accept;
    end else begin : g_pipe
      resp_entry_t          pipe_q [LATENCY-1];
      logic [LATENCY-2:0]   vld_q;

      always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
          vld_q <= '0;
          for (int i = 0; i < LATENCY - 1; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          vld_q[0]  <= accept;
          pipe_q[0] <= acc_ent;
          for (int i = 1; i < LATENCY - 1; i++) begin
            vld_q[i]  <= vld_q[i-1] && !flush;
            pipe_q[i] <= pipe_q[i-1];
          end
        end
      end

      assign fifo_ent = pipe_q[LATENCY-2];
      assign fifo_wr  = vld_q[LATENCY-2] && !flush;
    end
  endgenerate

  // Outstanding = in flight + queued; flush keeps only the redirect target.
  always_comb begin
    out_d = out_q;
    if (flush) begin
      out_d = accept ? OW'(1) : '0;
    end else if (accept && !pop) begin
      out_d = out_q + OW'(1);
    end else if (!accept && pop) begin
      out_d = out_q - OW'(1);
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  imem_resp_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .flush_i    (flush),
    .wr_i       (fifo_wr),
    .wr_data_i  (fifo_ent),
    .pop_i      (pop),
    .head_o     (head),
    .head_vld_o (head_vld)
  );

  assign resp_valid = head_vld;
  assign resp_inst  = head.inst;
  assign resp_addr  = head.addr;
  assign resp_fault = head.fault;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder (DEPTH_WORDS=1024, LATENCY=1, FIFO_DEPTH=2).
module tb_imem_responder;

  localparam logic [31:0] W0   = 32'h0050_0093;
  localparam logic [31:0] W1   = 32'h0010_0113;
  localparam logic [31:0] W2   = 32'h0020_8193;
  localparam logic [31:0] W4   = 32'h0000_0517;
  localparam logic [31:0] OLDW = 32'h0030_0213;
  localparam logic [31:0] NEWW = 32'h0040_0293;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_inst;
  logic [31:0] resp_addr;
  logic        resp_fault;
  logic        flush;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  int n_tests = 0;
  int n_fail  = 0;

  imem_responder #(
    .DEPTH_WORDS (1024),
    .LATENCY     (1),
    .FIFO_DEPTH  (2)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_inst  (resp_inst),
    .resp_addr  (resp_addr),
    .resp_fault (resp_fault),
    .flush      (flush),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input logic [31:0] a,
                          input logic [31:0] inst, input logic fault);
    chk({tag, "_valid"}, 32'(resp_valid), 32'h1);
    chk({tag, "_addr"},  resp_addr, a);
    chk({tag, "_inst"},  resp_inst, inst);
    chk({tag, "_fault"}, 32'(resp_fault), 32'(fault));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn       = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    resp_ready = 1'b0;
    flush      = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_inst",  resp_inst, 32'h0);
    chk("rst_resp_addr",  resp_addr, 32'h0);
    chk("rst_resp_fault", 32'(resp_fault), 32'h0);
    chk("rst_req_ready",  32'(req_ready), 32'h1);
    step();
    step();
    rstn = 1'b0;

    load(32'h0, W0);
    load(32'h4, W1);
    load(32'h8, W2);
    load(32'h10, W4);
    load(32'hC, OLDW);
    // Out-of-range write would alias word 0 if not dropped.
    load(32'h1000, 32'hFFFF_FFFF);

    // Back-to-back fetch
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h0;
    #1;
    chk("b2b_ready0", 32'(req_ready), 32'h1);
    step();
    req_addr = 32'h4;
    chk_resp("b2b_r0", 32'h0, W0, 1'b0);
    step();
    req_valid = 1'b0;
    chk_resp("b2b_r1", 32'h4, W1, 1'b0);
    step();
    chk("b2b_drained", 32'(resp_valid), 32'h0);

    // Backpressure
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h0;
    step();
    req_addr = 32'h4;
    #1;
    chk("bp_ready_second", 32'(req_ready), 32'h1);
    step();
    req_addr = 32'h8;
    #1;
    chk("bp_ready_full", 32'(req_ready), 32'h0);
    chk_resp("bp_head0", 32'h0, W0, 1'b0);
    step();
    chk_resp("bp_head0_hold", 32'h0, W0, 1'b0);
    chk("bp_ready_still_full", 32'(req_ready), 32'h0);
    resp_ready = 1'b1;
    #1;
    chk("bp_ready_on_pop", 32'(req_ready), 32'h1);
    step();
    req_valid = 1'b0;
    chk_resp("bp_head1", 32'h4, W1, 1'b0);
    step();
    chk_resp("bp_head2", 32'h8, W2, 1'b0);
    step();
    chk("bp_drained", 32'(resp_valid), 32'h0);

    // Flush with redirect
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h0;
    step();
    req_addr = 32'h4;
    step();
    flush    = 1'b1;
    req_addr = 32'h10;
    #1;
    chk("fl_ready", 32'(req_ready), 32'h1);
    step();
    flush     = 1'b0;
    req_valid = 1'b0;
    chk_resp("fl_target", 32'h10, W4, 1'b0);
    resp_ready = 1'b1;
    step();
    chk("fl_old_gone", 32'(resp_valid), 32'h0);

    // Out of range
    req_valid = 1'b1;
    req_addr  = 32'h1000;
    step();
    req_valid = 1'b0;
    chk_resp("oor", 32'h1000, NOP, 1'b1);
    step();

    // Misaligned
    req_valid = 1'b1;
    req_addr  = 32'h2;
    step();
    req_valid = 1'b0;
`ifdef IMEM_MISALIGN_CHECK_EN
    chk_resp("misalign", 32'h2, NOP, 1'b1);
`else
    chk_resp("misalign", 32'h2, W0, 1'b0);
`endif
    step();

    // Read-first on a same-cycle write to the fetched word
    req_valid = 1'b1;
    req_addr  = 32'hC;
    wr_en     = 1'b1;
    wr_addr   = 32'hC;
    wr_data   = NEWW;
    step();
    wr_en     = 1'b0;
    req_valid = 1'b0;
    chk_resp("rdfirst_old", 32'hC, OLDW, 1'b0);
    step();
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk_resp("rdfirst_new", 32'hC, NEWW, 1'b0);
    step();

    // Reset mid-operation with two queued responses
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h0;
    step();
    req_addr = 32'h4;
    step();
    req_valid = 1'b0;
    rstn      = 1'b1;
    #1;
    chk("mrst_resp_valid", 32'(resp_valid), 32'h0);
    chk("mrst_req_ready",  32'(req_ready), 32'h1);
    chk("mrst_resp_inst",  resp_inst, 32'h0);
    step();
    rstn = 1'b0;
    step();
    chk("mrst_empty_after", 32'(resp_valid), 32'h0);
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h4;
    step();
    req_valid = 1'b0;
    chk_resp("mrst_fetch", 32'h4, W1, 1'b0);
    step();
    chk("mrst_drained", 32'(resp_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the single-issue RISC-V core: the memory-side end of the fetch interface. It accepts fetch requests carrying the PC from the pc/npc front end and returns instruction words in order after a fixed pipeline latency. Responses are buffered in a small FIFO so the fetch stage can apply backpressure. A flush input discards wrong-path fetches when npc redirects on a branch, jal or jalr.

## Interface
- DEPTH_WORDS, 1024: memory size in 32-bit words; power of two.
- LATENCY, 1: read pipeline stages between accept and FIFO write; legal range 1..4.
- FIFO_DEPTH, 2: maximum outstanding fetches (in-flight plus queued); must be ≥1.
- clk  in  1  clock.
- rstn  in  1  reset; asynchronous, active-high.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  request can be accepted this cycle.
- req_addr  in  32  byte address (PC).
- resp_valid  out  1  head response valid.
- resp_ready  in  1  consumer takes head response.
- resp_inst  out  32  instruction word.
- resp_addr  out  32  echoed req_addr.
- resp_fault  out  1  fetch fault (out of range or misaligned).
- flush  in  1  discard all outstanding and queued fetches.
- wr_en  in  1  loader write strobe.
- wr_addr  in  32  loader byte address; bits [1:0] ignored.
- wr_data  in  32  loader data.

## Operation
- Accept: a request is accepted when req_valid && req_ready. It then enters the LATENCY-stage read pipeline carrying {addr, inst, fault}.
- outstanding counter, range 0..FIFO_DEPTH:
  - +1 on accept.
  - −1 on pop (resp_valid && resp_ready).
  - Both in the same cycle leaves it unchanged.
- req_ready = (outstanding < FIFO_DEPTH) || (resp_valid && resp_ready). This is a combinational path from resp_ready.
- Read index = req_addr[log2(DEPTH_WORDS)+1:2].
- Out of range (req_addr ≥ 4*DEPTH_WORDS): inst = NOP (0x0000_0013), fault = 1.
- The FIFO is written when the last pipeline stage holds a valid entry. Responses leave strictly in request order.
- Loader write: wr_en writes mem[wr_addr index]; out-of-range writes are dropped.
  - A read accepted in the same cycle as a write to the same word returns the old data (read-first).
- Flush:
  - Clears every pipeline valid bit, FIFO contents and outstanding, effective next cycle.
  - A request accepted in the flush cycle survives; it is the redirect target.
  - req_ready in the flush cycle is 1.
  - A pop in the flush cycle is still completed.
- Reset values: resp_valid 0, resp_inst 0, resp_addr 0, resp_fault 0, outstanding 0, all pipeline valids 0.
  - req_ready is 1 during and after reset.
  - Memory contents are not reset.

## Timing
- Request accepted at cycle T with the FIFO empty: resp_valid rises at T+LATENCY. resp_inst, resp_addr and resp_fault are registered.
- Full throughput of one response per cycle needs resp_ready held at 1 and FIFO_DEPTH ≥ LATENCY+1.
- FIFO full while resp_ready=0: req_ready=0 until a pop. Sustained pops give one accept per cycle.
- The head entry and resp_valid stay stable while resp_ready=0.
- Flush at cycle F: no pre-F response is visible from F+1 onward. A request accepted at F responds at F+LATENCY.
- rstn asserted mid-operation: all state clears asynchronously and resp_valid drops immediately.

## Configuration
- IMEM_MISALIGN_CHECK_EN defined:
  - req_addr[1:0] ≠ 0 returns NOP with fault=1.
  - The response still occupies one slot.
- Undefined: bits [1:0] are ignored, the aligned word is returned and fault is 0 unless the address is out of range.

## Structure
- imem_pkg holds the constant NOP_INST = 32'h0000_0013 and a struct/typedef for the response entry {addr[31:0], inst[31:0], fault}.
- Sub-module imem_resp_fifo: synchronous FIFO, parameterised by FIFO_DEPTH, with a flush input and a registered head. The read pipeline and counter stay in the top level.

## Test plan
- Back-to-back fetch:
  - Setup: load word0=0x00500093, word1=0x00100113; resp_ready=1.
  - Stimulus: request 0x0 then 0x4 on consecutive cycles.
  - Required: responses at T+1 and T+2 with these insts, matching addr, fault 0.
- Backpressure:
  - Stimulus: resp_ready=0; request 0x0, 0x4, 0x8.
  - Required: two accepted, req_ready=0 with 0x8 held. Release resp_ready → in-order 0x0, 0x4, then 0x8.
- Flush with redirect:
  - Stimulus: two outstanding; flush together with request 0x10.
  - Required: only the 0x10 response appears, one cycle later.
- Out of range: request 0x1000 (DEPTH_WORDS=1024) → inst 0x00000013, fault 1.
- Misaligned: request 0x2 → with the macro, NOP and fault 1; without it, word0 data and fault 0.
- Reset mid-operation:
  - Stimulus: rstn pulse with two queued responses.
  - Required: resp_valid 0 at once, req_ready 1; a fresh fetch of 0x4 returns 0x00100113.
